// File: rtl/fibonacci_gen.sv
// fibonacci_gen: registered Fibonacci lookup, fib = F(n) mod 2^WIDTH, one-cycle latency.
// The lookup table is a combinational chain of WIDTH-bit adders; only fib is stored.
// Optional build macro FIB_START_GATE_EN: when defined, fib updates only on edges
// with start=1 (reset still clears regardless). When undefined, start is ignored.
module fibonacci_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] fib
);

    localparam int DEPTH = 1 << WIDTH;

    logic [WIDTH-1:0] tbl [DEPTH];
    logic [WIDTH-1:0] fib_next;

`ifndef FIB_START_GATE_EN
    // start has no function in the ungated build
    logic unused_start;
    assign unused_start = start;
`endif

    // Unrolled modular recurrence; each entry is its own net so the chain is acyclic.
    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_fib
            logic [WIDTH-1:0] v;
            if (k == 0) begin : g_base0
                assign v = '0;
            end else if (k == 1) begin : g_base1
                assign v = {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin : g_sum
                assign v = g_fib[k-1].v + g_fib[k-2].v;
            end
            assign tbl[k] = v;
        end
    endgenerate

    // Select the table entry for the current index.
    always_comb begin
        fib_next = tbl[n];
    end

    // Register the selected entry; synchronous active-low reset has priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fib <= '0;
        end else begin
`ifdef FIB_START_GATE_EN
            if (start) begin
                fib <= fib_next;
            end
`else
            fib <= fib_next;
`endif
        end
    end

endmodule

// File: tb/tb_fibonacci_gen.sv
// Self-checking bench for fibonacci_gen: directed vector table, hand-written
// start-gate sequence, and randomized stimulus against a reference model.
module tb_fibonacci_gen;

    localparam int W = 8;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] n;
    logic [W-1:0] fib;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        bit           rst_v;
        bit           start_v;
        logic [W-1:0] n_v;
        logic [W-1:0] exp_v;
        string        name;
    } vec_t;

    vec_t vecs[$];

    fibonacci_gen #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .n     (n),
        .fib   (fib)
    );

    always #5 clk = ~clk;

    // Reference: iterate the pair (F(i), F(i+1)) with true integers, reduce mod 2^W.
    function automatic logic [W-1:0] ref_fib(int k);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < k; i++) begin
            t = (a + b) % MOD;
            a = b;
            b = t;
        end
        return a[W-1:0];
    endfunction

    task automatic add(bit r, bit s, int nv, int ev, string nm);
        vec_t v;
        v.rst_v = r;
        v.start_v = s;
        v.n_v = nv[W-1:0];
        v.exp_v = ev[W-1:0];
        v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: fib=%0d expected=%0d", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // Apply inputs just after a rising edge, then sample 1 time unit after the next edge.
    task automatic step(bit r, bit s, logic [W-1:0] nv);
        rst = r;
        start = s;
        n = nv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_q;
        bit r;
        bit s;
        logic [W-1:0] nv;

        rst = 1'b0;
        start = 1'b0;
        n = '0;
        @(posedge clk);
        #1;

        add(0, 1, 5,   0,   "reset_hold0");
        add(0, 1, 5,   0,   "reset_hold1");
        add(1, 1, 5,   5,   "reset_release");
        add(1, 1, 0,   0,   "n0");
        add(1, 1, 1,   1,   "n1");
        add(1, 1, 2,   1,   "n2");
        add(1, 1, 3,   2,   "n3");
        add(1, 1, 4,   3,   "n4");
        add(1, 1, 5,   5,   "n5");
        add(1, 1, 6,   8,   "n6");
        add(1, 1, 10,  55,  "n10_a");
        add(1, 1, 10,  55,  "n10_b");
        add(1, 1, 10,  55,  "n10_c");
        add(1, 1, 13,  233, "n13");
        add(1, 1, 14,  121, "n14_wrap");
        add(1, 1, 15,  98,  "n15_wrap");
        add(1, 1, 10,  55,  "stream_n10");
        add(0, 1, 10,  0,   "midstream_reset");
        add(1, 1, 10,  55,  "reset_recover");

        foreach (vecs[i]) begin
            step(vecs[i].rst_v, vecs[i].start_v, vecs[i].n_v);
            check(vecs[i].name, fib, vecs[i].exp_v);
        end

        step(1, 1, 8'd255);
        check("n255_max", fib, ref_fib(255));

        step(1, 1, 5);
        check("gate_load5", fib, 8'd5);
`ifdef FIB_START_GATE_EN
        step(1, 0, 10);
        check("gate_hold_a", fib, 8'd5);
        step(1, 0, 10);
        check("gate_hold_b", fib, 8'd5);
        step(1, 1, 10);
        check("gate_load55", fib, 8'd55);
        step(0, 0, 10);
        check("gate_reset_nostart", fib, 8'd0);
`else
        step(1, 0, 10);
        check("nogate_start0_a", fib, 8'd55);
        step(1, 0, 13);
        check("nogate_start0_b", fib, 8'd233);
        step(1, 1, 10);
        check("nogate_start1", fib, 8'd55);
        step(0, 0, 10);
        check("nogate_reset", fib, 8'd0);
`endif
        exp_q = '0;

        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 9) != 0);
            s = $urandom_range(0, 1) == 1;
            nv = W'($urandom_range(0, MOD - 1));
            step(r, s, nv);
            if (!r)
                exp_q = '0;
`ifdef FIB_START_GATE_EN
            else if (s)
                exp_q = ref_fib(int'(nv));
`else
            else
                exp_q = ref_fib(int'(nv));
`endif
            check("random", fib, exp_q);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
